// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_boot_loader
//  Description : Boot-time loader that sits in front of the CPU instruction
//                memory. A byte stream arrives over a valid/ready interface:
//                a 4-byte big-endian word count N, then N big-endian 32-bit
//                instruction words, then a 4-byte XOR checksum over those
//                words. Words are written to IM word addresses 0..N-1. The
//                CPU is released (cpu_run) only once the checksum matches.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   system clock, rising edge
//    rst_n     in   synchronous reset, ACTIVE HIGH (name kept from CPU top)
//    start     in   begin a load; honoured in IDLE and ERR only
//    rx_data   in   [7:0]  incoming image byte
//    rx_valid  in   rx_data valid
//    rx_ready  out  loader can accept a byte (state decode only)
//    im_we     out  IM write strobe, one cycle per word
//    im_addr   out  [ADDR_W-1:0] IM word address
//    im_wdata  out  [31:0] IM write data
//    word_cnt  out  [ADDR_W:0] words written in the current load
//    cpu_run   out  image loaded and verified
//    done      out  load completed successfully
//    error     out  load failed (bad length or checksum)
// ============================================================================
module imem_boot_loader #(
    parameter int ADDR_W    = 12,
    parameter int MAX_WORDS = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [ADDR_W:0]   word_cnt,
    output logic              cpu_run,
    output logic              done,
    output logic              error
);

    localparam logic [31:0]   c_max_words = 32'(MAX_WORDS);
    localparam logic [ADDR_W:0] c_cnt_one = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_LOAD = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Only the three most recent bytes need to be kept: the fourth byte is
    // taken straight from rx_data when the word completes.
    logic [23:0]       r_shift;
    logic [1:0]        r_byte_cnt;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_word_cnt;
    logic [31:0]       r_csum;
    logic              r_im_we;
    logic [ADDR_W-1:0] r_im_addr;
    logic [31:0]       r_im_wdata;
    logic              r_done;
    logic              r_cpu_run;
    logic              r_error;

    logic              w_hs;
    logic              w_last_byte;
    logic [31:0]       w_word;
    logic              w_len_bad;
    logic              w_last_word;
    logic              w_enter_hdr;

    // ------------------------------------------------------------------------
    // Handshake and word assembly
    // ------------------------------------------------------------------------
    // rx_ready depends on the state register alone, so there is no
    // combinational path from rx_valid back to rx_ready.
    assign rx_ready    = (r_state == S_HDR) || (r_state == S_LOAD) || (r_state == S_CHK);
    assign w_hs        = rx_valid & rx_ready;
    assign w_last_byte = w_hs && (r_byte_cnt == 2'd3);
    assign w_word      = {r_shift, rx_data};

    // Full 32-bit compare so that huge header values are rejected rather
    // than silently truncated.
    assign w_len_bad   = (w_word == 32'd0) || (w_word > c_max_words);

    // True while the word being completed is the final one of the image.
    assign w_last_word = ((r_word_cnt + c_cnt_one) == r_len);

    assign w_enter_hdr = start && ((r_state == S_IDLE) || (r_state == S_ERR));

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (w_last_byte) begin
                    w_state_nxt = w_len_bad ? S_ERR : S_LOAD;
                end
            end
            S_LOAD: begin
                // Leave on the edge that launches the final write, so the
                // checksum bytes can follow the last word with no bubble.
                if (w_last_byte && w_last_word) begin
                    w_state_nxt = S_CHK;
                end
            end
            S_CHK: begin
                if (w_last_byte) begin
                    w_state_nxt = (w_word == r_csum) ? S_DONE : S_ERR;
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            S_ERR: begin
                if (start) begin
                    w_state_nxt = S_HDR;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_len      <= '0;
            r_word_cnt <= '0;
            r_csum     <= '0;
            r_im_we    <= 1'b0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
            r_done     <= 1'b0;
            r_cpu_run  <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            // Status flags follow the state being entered, so they are
            // registered and change on the same edge as the state.
            r_im_we   <= 1'b0;
            r_done    <= (w_state_nxt == S_DONE);
            r_cpu_run <= (w_state_nxt == S_DONE);
            r_error   <= (w_state_nxt == S_ERR);

            if (w_enter_hdr) begin
                r_word_cnt <= '0;
                r_csum     <= '0;
                r_byte_cnt <= '0;
            end

            // Handshakes only happen in HDR/LOAD/CHK, so this never
            // collides with the clear above.
            if (w_hs) begin
                r_shift    <= {r_shift[15:0], rx_data};
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end

            if (w_last_byte && (r_state == S_HDR) && !w_len_bad) begin
                r_len <= w_word[ADDR_W:0];
            end

            // Word complete: launch the IM write for the next cycle and
            // account for it (count and checksum) on the same edge.
            if (w_last_byte && (r_state == S_LOAD)) begin
                r_im_we    <= 1'b1;
                r_im_addr  <= r_word_cnt[ADDR_W-1:0];
                r_im_wdata <= w_word;
                r_word_cnt <= r_word_cnt + c_cnt_one;
                r_csum     <= r_csum ^ w_word;
            end
        end
    end

    assign im_we    = r_im_we;
    assign im_addr  = r_im_addr;
    assign im_wdata = r_im_wdata;
    assign word_cnt = r_word_cnt;
    assign done     = r_done;
    assign cpu_run  = r_cpu_run;
    assign error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_boot_loader
//  Description : Self-checking bench for imem_boot_loader. Expected IM writes
//                are queued as stimulus is issued; a forked monitor pops and
//                compares on every im_we cycle. Status outputs are checked
//                against hand-computed values at the end of each scenario.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_boot_loader;

    localparam int ADDR_W    = 12;
    localparam int MAX_WORDS = 4096;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic [ADDR_W:0]   word_cnt;
    logic              cpu_run;
    logic              done;
    logic              error;

    int checks;
    int errors;

    // Expected writes: {addr, data}
    logic [ADDR_W+31:0] exp_q[$];

    imem_boot_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .word_cnt (word_cnt),
        .cpu_run  (cpu_run),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one byte after 'gap' idle cycles; returns at the negedge after
    // the handshake edge, with rx_valid dropped.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: rx_ready stayed 0 for byte 0x%02h, expected 1", b);
        end else begin
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int k = 3; k >= 0; k--) begin
            send_byte(w[8*k +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_im_we",    32'(im_we),    32'd0);
        chk("rst_im_addr",  32'(im_addr),  32'd0);
        chk("rst_im_wdata", im_wdata,      32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_cpu_run",  32'(cpu_run),  32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_error",    32'(error),    32'd0);
        rst_n = 1'b0;
        @(negedge clk);
    endtask

    // Scenario-1 image (header, two words, checksum) with optional gaps.
    task automatic load_small(input logic [31:0] csum, input int maxgap);
        send_word(32'h0000_0002, maxgap);
        exp_q.push_back({12'd0, 32'h2408_0005});
        send_word(32'h2408_0005, maxgap);
        exp_q.push_back({12'd1, 32'h0800_0000});
        send_word(32'h0800_0000, maxgap);
        send_word(csum, maxgap);
    endtask

    task automatic chk_status(input string tag, input logic d, input logic r, input logic e);
        chk({tag, "_done"},    32'(done),    32'(d));
        chk({tag, "_cpu_run"}, 32'(cpu_run), 32'(r));
        chk({tag, "_error"},   32'(error),   32'(e));
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] x;
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Write monitor: every im_we cycle must match the head of the queue.
        fork
            forever begin
                @(negedge clk);
                if (im_we === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: addr %0d data 0x%08h, expected no write",
                                 im_addr, im_wdata);
                    end else begin
                        logic [ADDR_W+31:0] e;
                        e = exp_q.pop_front();
                        if ({im_addr, im_wdata} !== e) begin
                            errors++;
                            $display("FAIL im_write: addr %0d data 0x%08h, expected addr %0d data 0x%08h",
                                     im_addr, im_wdata, e[ADDR_W+31:32], e[31:0]);
                        end
                    end
                end
            end
        join_none

        // 1: basic back-to-back load
        do_reset();
        pulse_start();
        load_small(32'h2C08_0005, 0);
        chk_status("t1", 1'b1, 1'b1, 1'b0);
        chk("t1_word_cnt", 32'(word_cnt), 32'd2);
        chk("t1_rx_ready", 32'(rx_ready), 32'd0);

        // 2: bad checksum, then recover from ERR
        do_reset();
        pulse_start();
        load_small(32'h2C08_0004, 0);
        chk_status("t2_bad", 1'b0, 1'b0, 1'b1);
        chk("t2_rx_ready", 32'(rx_ready), 32'd0);
        pulse_start();
        chk("t2_err_clr", 32'(error), 32'd0);
        load_small(32'h2C08_0005, 0);
        chk_status("t2_ok", 1'b1, 1'b1, 1'b0);

        // 3: zero length, then over-length header
        do_reset();
        pulse_start();
        send_word(32'h0000_0000, 0);
        chk_status("t3_zero", 1'b0, 1'b0, 1'b1);
        chk("t3_zero_rx_ready", 32'(rx_ready), 32'd0);
        pulse_start();
        send_word(32'h0000_1001, 0);
        chk_status("t3_big", 1'b0, 1'b0, 1'b1);
        chk("t3_word_cnt", 32'(word_cnt), 32'd0);

        // 4: random gaps on rx_valid
        do_reset();
        pulse_start();
        load_small(32'h2C08_0005, 5);
        chk_status("t4", 1'b1, 1'b1, 1'b0);
        chk("t4_word_cnt", 32'(word_cnt), 32'd2);

        // 5: reset after 6 LOAD bytes, then a full reload from address 0
        do_reset();
        pulse_start();
        send_word(32'h0000_0002, 0);
        exp_q.push_back({12'd0, 32'h2408_0005});
        send_word(32'h2408_0005, 0);
        send_byte(8'h08, 0);
        send_byte(8'h00, 0);
        do_reset();
        pulse_start();
        load_small(32'h2C08_0005, 0);
        chk_status("t5", 1'b1, 1'b1, 1'b0);

        // 6: maximum-length image; start in DONE has no effect
        do_reset();
        pulse_start();
        send_word(32'(MAX_WORDS), 0);
        x = 32'd0;
        for (int i = 0; i < MAX_WORDS; i++) begin
            w = (32'(i) * 32'h0001_0001) ^ 32'hDEAD_BEEF;
            x = x ^ w;
            exp_q.push_back({12'(i), w});
            send_word(w, 0);
        end
        send_word(x, 0);
        chk_status("t6", 1'b1, 1'b1, 1'b0);
        chk("t6_word_cnt", 32'(word_cnt), 32'(MAX_WORDS));
        pulse_start();
        repeat (3) @(negedge clk);
        chk_status("t6_start_in_done", 1'b1, 1'b1, 1'b0);
        chk("t6_rx_ready", 32'(rx_ready), 32'd0);

        repeat (2) @(negedge clk);
        chk("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
